// File: rtl/comm_frame_rx_if.sv
// Frame receiver bus: serial line in, deserialised frame and status out.
interface comm_frame_rx_if #(
  parameter int DATA_NUM = 64
);
  logic                Serial_data;
  logic [DATA_NUM:0]   data_o;
  logic [15:0]         crc_cal;
  logic                start;
  logic                non_frame;

  // receiver side
  modport master (
    input  Serial_data,
    output data_o,
    output crc_cal,
    output start,
    output non_frame
  );

  // line driver / downstream CRC-check side
  modport slave (
    output Serial_data,
    input  data_o,
    input  crc_cal,
    input  start,
    input  non_frame
  );
endinterface

// File: rtl/comm_frame_rx.sv
// Serial NRZ frame receiver: start bit, DATA_NUM data bits (payload then CRC),
// stop bit. Computes CRC-16/CCITT-FALSE over the payload while receiving.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a falling edge on the synchronised line
// START_CHK | half a bit in, confirm the start bit is still low
// DATA      | sample one data bit per BIT_CLKS at mid-bit
// STOP      | sample stop bit, deliver frame and strobe start
module comm_frame_rx #(
  parameter int DATA_NUM = 64,
  parameter int BIT_CLKS = 40
) (
  input  logic            clk_20M,
  input  logic            reset_n,
  comm_frame_rx_if.master rx_if
);

  localparam int          PAY_BITS = DATA_NUM - 16;
  localparam logic [15:0] MID_CNT  = 16'(BIT_CLKS / 2 - 1);
  localparam logic [15:0] LAST_CNT = 16'(BIT_CLKS - 1);
  localparam logic [6:0]  LAST_IDX = 7'(DATA_NUM - 1);
  localparam logic [6:0]  PAY_IDX  = 7'(PAY_BITS);

  typedef enum logic [1:0] {IDLE, START_CHK, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic                sync1, sync2, sync3;
  logic                rxs, fall;
  logic [15:0]         bit_cnt;
  logic [6:0]          bit_idx;
  logic [DATA_NUM-1:0] shreg;
  logic [15:0]         crc_q, crc_next;
  logic                mid_bit;
  logic                load_cnt, frame_init, shift_en, deliver;
  logic                fb;

  assign rxs     = sync2;
  assign fall    = sync3 & ~sync2;
  assign mid_bit = (bit_cnt == MID_CNT);

  // Two-stage synchroniser plus edge register; reset high so no edge after reset.
  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rx_if.Serial_data;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_20M) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_d    = state_q;
    load_cnt   = 1'b0;
    frame_init = 1'b0;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          load_cnt = 1'b1;
          state_d  = START_CHK;
        end
      end
      START_CHK: begin
        if (mid_bit) begin
          if (!rxs) begin
            frame_init = 1'b1;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_IDX) state_d = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.non_frame = (state_q == IDLE);

  // Bit timer: free-runs through the frame, wrapping once per bit period.
  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (load_cnt) begin
      bit_cnt <= '0;
    end else if (state_q != IDLE) begin
      bit_cnt <= (bit_cnt == LAST_CNT) ? 16'd0 : bit_cnt + 16'd1;
    end
  end

  // Serial CRC-16 step, poly 0x1021, MSB first.
  always_comb begin
    fb       = crc_q[15] ^ rxs;
    crc_next = {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

  // Shift register, bit index and running CRC; CRC covers payload bits only.
  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_idx <= '0;
      crc_q   <= 16'hFFFF;
    end else if (frame_init) begin
      shreg   <= '0;
      bit_idx <= '0;
      crc_q   <= 16'hFFFF;
    end else if (shift_en) begin
      shreg   <= {shreg[DATA_NUM-2:0], rxs};
      bit_idx <= bit_idx + 7'd1;
      if (bit_idx < PAY_IDX) crc_q <= crc_next;
    end
  end

  // Output registers: loaded with the start strobe at the stop-bit sample.
  always_ff @(posedge clk_20M) begin
    if (!reset_n) begin
      rx_if.data_o  <= '0;
      rx_if.crc_cal <= '0;
      rx_if.start   <= 1'b0;
    end else begin
      rx_if.start <= deliver;
      if (deliver) begin
        rx_if.data_o  <= {~rxs, shreg[15:0], shreg[DATA_NUM-1:16]};
        rx_if.crc_cal <= crc_q;
      end
    end
  end

endmodule

// File: tb/tb_comm_frame_rx.sv
// Self-checking bench for comm_frame_rx: table of frames plus corner sequences.
module tb_comm_frame_rx;
  localparam int DATA_NUM = 64;
  localparam int BIT_CLKS = 40;
  localparam int NVEC     = 6;

  logic clk_20M = 1'b0;
  logic reset_n = 1'b0;
  always #25 clk_20M = ~clk_20M;

  comm_frame_rx_if #(.DATA_NUM(DATA_NUM)) rx_if ();

  comm_frame_rx #(.DATA_NUM(DATA_NUM), .BIT_CLKS(BIT_CLKS)) dut (
    .clk_20M (clk_20M),
    .reset_n (reset_n),
    .rx_if   (rx_if)
  );

  typedef struct {
    logic [47:0] payload;
    logic [15:0] crc_tx;
    logic        stop_bit;
    int          gap_bits;
    logic [64:0] exp_data;
    logic [15:0] exp_crc;
  } vec_t;

  typedef struct {
    logic [64:0] data;
    logic [15:0] crc;
  } exp_t;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_start  = 0;
  int          cyc      = 0;
  int          start_cyc = 0;
  int          frame_cyc = 0;
  logic [64:0] last_exp = '0;

  always @(posedge clk_20M) cyc <= cyc + 1;

  function automatic logic [15:0] crc16(input logic [47:0] p);
    logic [15:0] c;
    logic        f;
    c = 16'hFFFF;
    for (int i = 47; i >= 0; i--) begin
      f = c[15] ^ p[i];
      c = {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input logic [47:0] p, input logic [15:0] c,
                         input logic stop, input int gap);
    vecs[i].payload  = p;
    vecs[i].crc_tx   = c;
    vecs[i].stop_bit = stop;
    vecs[i].gap_bits = gap;
    vecs[i].exp_data = {~stop, c, p};
    vecs[i].exp_crc  = crc16(p);
  endtask

  task automatic push_exp(input logic [64:0] d, input logic [15:0] c);
    exp_t e;
    e.data = d;
    e.crc  = c;
    sb_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk_20M);
      if (rx_if.start === 1'b1) begin
        n_start++;
        check("start_single_cycle", 65'(prev), 65'd0);
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_start: start seen at cycle %0d, required none", cyc);
        end else begin
          e = sb_q.pop_front();
          check("data_o", rx_if.data_o, e.data);
          check("crc_cal", 65'(rx_if.crc_cal), 65'(e.crc));
          last_exp  = e.data;
          start_cyc = cyc;
        end
      end
      prev = rx_if.start;
    end
  endtask

  // Drive one frame starting at a negedge; abort_bit >= 0 pulses reset mid that data bit.
  task automatic send_frame(input logic [47:0] p, input logic [15:0] c,
                            input logic stop, input int abort_bit);
    logic [63:0] bits;
    bits = {p, c};
    rx_if.Serial_data = 1'b0;
    frame_cyc = cyc;
    repeat (BIT_CLKS) @(negedge clk_20M);
    for (int i = 63; i >= 0; i--) begin
      rx_if.Serial_data = bits[i];
      if ((63 - i) == abort_bit) begin
        repeat (BIT_CLKS / 2) @(negedge clk_20M);
        reset_n = 1'b0;
        @(negedge clk_20M);
        reset_n = 1'b1;
        rx_if.Serial_data = 1'b1;
        return;
      end
      repeat (BIT_CLKS) @(negedge clk_20M);
    end
    rx_if.Serial_data = stop;
    repeat (BIT_CLKS) @(negedge clk_20M);
    rx_if.Serial_data = 1'b1;
  endtask

  initial begin
    logic [63:0] rnd;
    int          low_cnt;
    int          n0;
    int          nf_bad;
    logic [47:0] gp;

    rx_if.Serial_data = 1'b1;
    reset_n = 1'b0;
    fork
      monitor();
    join_none

    repeat (5) @(negedge clk_20M);
    check("reset_data_o", rx_if.data_o, 65'd0);
    check("reset_crc_cal", 65'(rx_if.crc_cal), 65'd0);
    check("reset_start", 65'(rx_if.start), 65'd0);
    check("reset_non_frame", 65'(rx_if.non_frame), 65'd1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_20M);
    check("idle_non_frame", 65'(rx_if.non_frame), 65'd1);

    rnd = {$urandom, $urandom};
    set_vec(0, 48'h313233343536, crc16(48'h313233343536), 1'b1, 2);
    set_vec(1, 48'h0, 16'h0000, 1'b1, 2);
    set_vec(2, 48'hA5A55A5AF00F, crc16(48'hA5A55A5AF00F), 1'b0, 3);
    set_vec(3, 48'hFFFFFFFFFFFF, crc16(48'hFFFFFFFFFFFF) ^ 16'h8001, 1'b1, 0);
    set_vec(4, rnd[47:0], crc16(rnd[47:0]), 1'b1, 0);
    set_vec(5, 48'h800000000001, crc16(48'h800000000001), 1'b1, 2);

    for (int i = 0; i < NVEC; i++) begin
      push_exp(vecs[i].exp_data, vecs[i].exp_crc);
      send_frame(vecs[i].payload, vecs[i].crc_tx, vecs[i].stop_bit, -1);
      if (i == 0)
        check("start_latency", 65'(start_cyc - frame_cyc),
              65'(3 + BIT_CLKS / 2 + (DATA_NUM + 1) * BIT_CLKS));
      repeat (vecs[i].gap_bits * BIT_CLKS) @(negedge clk_20M);
    end
    repeat (4) @(negedge clk_20M);
    check("table_all_delivered", 65'(sb_q.size()), 65'd0);
    check("table_start_count", 65'(n_start), 65'(NVEC));

    // Glitch: 10-cycle low pulse must be rejected as a false start.
    n0 = n_start;
    low_cnt = 0;
    for (int k = 0; k < 110; k++) begin
      rx_if.Serial_data = (k < 10) ? 1'b0 : 1'b1;
      @(negedge clk_20M);
      if (rx_if.non_frame === 1'b0) low_cnt++;
    end
    check("glitch_non_frame_low_bounded",
          65'((low_cnt > 0) && (low_cnt <= BIT_CLKS / 2 + 2)), 65'd1);
    check("glitch_no_start", 65'(n_start), 65'(n0));
    check("glitch_non_frame_back", 65'(rx_if.non_frame), 65'd1);
    check("glitch_data_o_held", rx_if.data_o, last_exp);

    // Stuck-low after a good frame: one stop-error frame of zeros, then nothing.
    gp = 48'h0123456789AB;
    push_exp({1'b0, crc16(gp), gp}, crc16(gp));
    push_exp({1'b1, 16'h0000, 48'h0}, crc16(48'h0));
    send_frame(gp, crc16(gp), 1'b1, -1);
    rx_if.Serial_data = 1'b0;
    repeat (3000) @(negedge clk_20M);
    check("stuck_frames_delivered", 65'(sb_q.size()), 65'd0);
    n0 = n_start;
    nf_bad = 0;
    repeat (7000) begin
      @(negedge clk_20M);
      if (rx_if.non_frame !== 1'b1) nf_bad++;
    end
    check("stuck_non_frame_high", 65'(nf_bad), 65'd0);
    check("stuck_no_more_start", 65'(n_start), 65'(n0));
    rx_if.Serial_data = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clk_20M);

    // Reset during data bit 30 aborts the frame.
    n0 = n_start;
    send_frame(48'hDEADBEEF0042, crc16(48'hDEADBEEF0042), 1'b1, 30);
    check("abort_data_o", rx_if.data_o, 65'd0);
    check("abort_crc_cal", 65'(rx_if.crc_cal), 65'd0);
    check("abort_non_frame", 65'(rx_if.non_frame), 65'd1);
    check("abort_start", 65'(rx_if.start), 65'd0);
    repeat (4 * BIT_CLKS) @(negedge clk_20M);
    check("abort_no_start", 65'(n_start), 65'(n0));

    gp = 48'h313233343536;
    push_exp({1'b0, crc16(gp), gp}, crc16(gp));
    send_frame(gp, crc16(gp), 1'b1, -1);
    repeat (2 * BIT_CLKS) @(negedge clk_20M);
    check("post_reset_delivered", 65'(sb_q.size()), 65'd0);
    check("post_reset_start_count", 65'(n_start), 65'(n0 + 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
